pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_hazard_cmp.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared CPU defines: register address width, hazard FSM states, NOP encoding
`ifndef RegAddrWidth
`define RegAddrWidth 5
`endif

package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = `RegAddrWidth;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_WAIT  = 2'd1,
    ST_MC_DRAIN = 2'd2
  } hz_state_e;

  // sll $0,$0,0 -- what a bubbled pipeline register carries
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// rtl/pipe_hazard_ctrl_hazard_cmp.sv - combinational load-use comparator between EX load and ID sources
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_read_mem_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  output logic                  load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs_i && (id_rs_addr_i == ex_rt_i);
  assign rt_hit = id_uses_rt_i && (id_rt_addr_i == ex_rt_i);

  // $0 is hardwired, so a load into it never produces a value worth waiting for
  assign load_use_o = ex_read_mem_i && (ex_rt_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/bubble/flush control with multicycle handshake
// Optional multicycle timeout/abort enabled by HAZARD_MC_TIMEOUT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_branch_taken,
  input  logic                  ex_ReadMem,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_mc_req,
  input  logic                  mc_done,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_stall,
  output logic                  idex_bubble,
  output logic                  exmem_bubble,
  output logic                  ifid_flush,
  output logic                  mc_start,
  output logic                  mc_abort
);

  if (MC_TIMEOUT < 1) begin : g_bad_timeout
    $error("MC_TIMEOUT must be at least 1");
  end

  hz_state_e state_q, state_d;
  logic      load_use;
  logic      in_run;
  logic      mc_hold;
  logic      lu_stall;
  logic      timeout_hit;

  hazard_cmp u_hazard_cmp (
    .id_rs_addr_i  (id_rs_addr),
    .id_rt_addr_i  (id_rt_addr),
    .id_uses_rs_i  (id_uses_rs),
    .id_uses_rt_i  (id_uses_rt),
    .ex_read_mem_i (ex_ReadMem),
    .ex_rt_i       (ex_rt),
    .load_use_o    (load_use)
  );

  // Outputs are gated by rst so nothing leaks through from live inputs during reset
  assign in_run   = rst && (state_q == ST_RUN);
  assign mc_hold  = (in_run && ex_mc_req) || (rst && (state_q == ST_MC_WAIT));
  assign lu_stall = in_run && !ex_mc_req && load_use;

  assign pc_stall     = mc_hold || lu_stall;
  assign ifid_stall   = mc_hold || lu_stall;
  assign idex_stall   = mc_hold;
  assign idex_bubble  = lu_stall;
  assign exmem_bubble = mc_hold;
  assign ifid_flush   = rst && id_branch_taken && !(mc_hold || lu_stall);
  assign mc_start     = in_run && ex_mc_req;
  assign mc_abort     = rst && timeout_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (ex_mc_req) state_d = ST_MC_WAIT;
      ST_MC_WAIT:  if (mc_done || timeout_hit) state_d = ST_MC_DRAIN;
      ST_MC_DRAIN: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_MC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MC_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the 1-based index of the current MC_WAIT cycle; mc_done on the last cycle wins
  assign timeout_hit = (state_q == ST_MC_WAIT) && !mc_done && (cnt_q == CNT_W'(MC_TIMEOUT));

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_RUN && ex_mc_req) begin
      cnt_d = CNT_W'(1);
    end else if (state_q == ST_MC_WAIT && state_d == ST_MC_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
